rf_wb_arbiter: RTL

Shares the single register-file write port (A3/WD3/WE3) among NUM_REQ writeback requesters, e.g. ALU result, load data and multiply/divide result.
- Per-requester valid/ready handshake; round-robin grant; one registered output stage driving the register file.
- Suppresses writes to register 0 so $zero stays constant.
- Sits between the execute/memory writeback sources and the register file.

---
 rtl/rf_wb_arbiter_pkg.sv | 13 +
 rtl/rf_wb_arbiter_rr.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and stage state encoding for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_ZERO           = 0;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  typedef enum logic {
    STAGE_EMPTY = 1'b0,
    STAGE_FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Generic round-robin arbiter: search starts one past the last winner, pointer moves on advance.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset pointer sits on the last requester so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources through one output stage.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 3,
  parameter  int unsigned DataWidth    = DEFAULT_DATA_WIDTH,
  parameter  int unsigned Addres_depth = DEFAULT_ADDR_WIDTH,
  localparam int unsigned IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            RST,
  input  logic                            wb_hold,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*Addres_depth-1:0] req_addr,
  input  logic [NUM_REQ*DataWidth-1:0]    req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            WE3,
  output logic [Addres_depth-1:0]         A3,
  output logic [DataWidth-1:0]            WD3,
  output logic [IDX_W-1:0]                grant_idx
);

  stage_state_t              state_q, state_d;
  logic [Addres_depth-1:0]   stage_addr;
  logic [DataWidth-1:0]      stage_data;
  logic [NUM_REQ-1:0]        arb_grant;
  logic [IDX_W-1:0]          arb_idx;
  logic [Addres_depth-1:0]   sel_addr;
  logic [DataWidth-1:0]      sel_data;
  logic                      transfer;
  logic                      load;
  logic                      drain;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (RST),
    .req       (req_valid),
    .advance   (transfer),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // With hold low the stage always drains, so a grant never has to wait on the stage.
  assign req_ready = wb_hold ? '0 : arb_grant;
  assign transfer  = |req_ready;
  assign drain     = (state_q == STAGE_FULL) && !wb_hold;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sel_addr = sel_addr | (req_addr[i*Addres_depth +: Addres_depth] & {Addres_depth{arb_grant[i]}});
      sel_data = sel_data | (req_data[i*DataWidth +: DataWidth] & {DataWidth{arb_grant[i]}});
    end
  end

  // Writes to register 0 are acknowledged but never reach the stage.
  assign load = transfer && (sel_addr != Addres_depth'(REG_ZERO));

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = STAGE_FULL;
    end else if (drain) begin
      state_d = STAGE_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= STAGE_EMPTY;
      stage_addr <= '0;
      stage_data <= '0;
      grant_idx  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        stage_addr <= sel_addr;
        stage_data <= sel_data;
      end
      if (transfer) begin
        grant_idx <= arb_idx;
      end
    end
  end

  assign WE3 = drain;
  assign A3  = stage_addr;
  assign WD3 = stage_data;

endmodule
